ebm_rd: RTL and testbench
=========================

Name: ebm_rd

Overview:
- Egress buffer manager read side. It consumes the 8-bit buffer-ID metadata emitted by the egress output scheduler, streams that packet's 134-bit words from packet buffer RAM to the UDO pktout FIFO, and returns the buffer ID to the free pool.
- It drives the pkt_valid request back to the scheduler and honours the scheduler's bandwidth_discard reply, dropping the packet without transmission when told to.

Parameters:
- WORD_W, 7: word-index width; max 128 words per buffer.
- MD_FIFO_AW, 4: metadata FIFO address width; depth 16.
- PKTOUT_AFULL, 8'd240: stop issuing reads when pktout usedw exceeds this value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_ebm_md  in  8  buffer ID from scheduler
- in_ebm_md_wr  in  1  md strobe
- out_ebm_pkt_valid  out  1  1-cycle pulse: packet word0 fetched, bandwidth check request
- in_ebm_bandwidth_discard  in  1  scheduler reply, sampled the cycle after pkt_valid
- out_ebm_buf_rd_en  out  1  buffer RAM read enable
- out_ebm_buf_rd_addr  out  8+WORD_W  {buffer_id, word_idx}
- in_ebm_buf_rd_data  in  134  RAM data, valid 1 cycle after rd_en
- out_ebm_pkt  out  134  word to UDO; [133:132] 01=first, 11=middle, 10=last
- out_ebm_pkt_wr  out  1  word strobe
- in_ebm_pktout_usedw  in  8  UDO FIFO fill level
- out_ebm_free_id  out  8  released buffer ID
- out_ebm_free_id_wr  out  1  release strobe
- out_ebm_pkt_cnt  out  32  packets sent
- out_ebm_discard_cnt  out  32  packets dropped on discard reply
- out_ebm_md_ovf_cnt  out  32  md writes lost to a full md FIFO

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE.
  - md FIFO is empty.
- The async reset aborts any packet in progress. No free_id is issued for the aborted buffer; the pool is reinitialised elsewhere on reset.
- md FIFO:
  - Write on in_ebm_md_wr when the FIFO is not full.
  - When full, drop the md and increment ovf_cnt.
  - Show-ahead read.
- FSM states:
  - IDLE: when the FIFO is not empty and usedw <= PKTOUT_AFULL:
    - pop the FIFO and latch the ID;
    - rd_en=1, addr={ID,0};
    - go to FETCH.
  - FETCH: capture RAM data into hold register; pulse pkt_valid; go to CHK.
  - CHK: sample in_ebm_bandwidth_discard.
    - If discard=1: free_id_wr=1 with the ID, discard_cnt+1, go to IDLE.
    - If discard=0: emit the hold word with pkt_wr=1.
      - If its header is 10: free_id_wr=1, pkt_cnt+1, go to IDLE.
      - Otherwise: word_idx=1, go to SEND.
  - SEND, read issue: each cycle, rd_en=1 at {ID,word_idx} and word_idx+1, unless either of these holds:
    - usedw > PKTOUT_AFULL (stall, no read that cycle);
    - the last word has already been issued.
  - SEND, write-back: each returned word is written out one cycle after its read.
    - A word returning with header 10 ends the packet: free_id_wr=1 and pkt_cnt+1 in the same cycle as its pkt_wr, then go to IDLE.
    - Any reads issued past the last word are discarded and never written.
  - Truncation: the word at word_idx = 2^WORD_W-1 is forced to header 10 and ends the packet as above.
- Latency:
  - md at FIFO head to pkt_valid: 2 cycles.
  - pkt_valid to first pkt_wr: 1 cycle.
  - Steady state without stall: 1 word/cycle.
- Throughput: at least 1 idle cycle between packets (the IDLE state).
- Simultaneous events: an md write coinciding with a pop while full counts as a successful write (a slot frees that cycle).
- Counters are 32-bit and wrap silently.
- At most one free_id_wr per packet, always in the packet's final cycle.

Decomposition:
- Shared package:
  - header codes HDR_FIRST=2'b01, HDR_MID=2'b11, HDR_LAST=2'b10;
  - PKT_W=134;
  - FSM state encodings.
- One sub-module: ebm_md_fifo, a synchronous show-ahead FIFO of width 8 and depth 2^MD_FIFO_AW, with full, empty and usedw outputs.

Test Plan:
- md=0x05, buffer 5 holds 3 words (01,11,10), discard=0, usedw=0 -> pkt_valid 2 cycles after md, pkt_wr on 3 consecutive cycles, free_id=0x05 with the last word, pkt_cnt=1.
- md=0x07, discard=1 in the cycle after pkt_valid -> no pkt_wr, free_id=0x07 in the CHK cycle, discard_cnt=1.
- Single-word packet (header 10) in buffer 0x09 -> exactly one pkt_wr and free_id=0x09 in the same cycle, then IDLE.
- usedw forced to 241 mid-packet for 4 cycles -> no rd_en during the stall, no words lost or duplicated, output order preserved.
- 18 back-to-back md writes while usedw=255 -> 16 buffered, ovf_cnt=2; after usedw drops to 0, 16 packets leave in FIFO order.
- Buffer with 128 words and no 10 header -> 128 pkt_wr, last word header forced to 10, free_id issued; a reset asserted mid-packet returns all outputs and counters to 0 at once.

Source files
------------

// File: rtl/ebm_rd_pkg.sv
// Shared definitions for the egress buffer manager read side: word layout,
// header codes, default sizing and FSM state encoding.
package ebm_rd_pkg;

   localparam int         PKT_W            = 134;
   localparam int         EBM_WORD_W       = 7;
   localparam int         EBM_MD_FIFO_AW   = 4;
   localparam logic [7:0] EBM_PKTOUT_AFULL = 8'd240;

   localparam logic [1:0] HDR_FIRST = 2'b01;
   localparam logic [1:0] HDR_MID   = 2'b11;
   localparam logic [1:0] HDR_LAST  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_CHK   = 2'd2,
      ST_SEND  = 2'd3
   } ebm_state_t;

   function automatic logic [1:0] hdr_of(input logic [PKT_W-1:0] word);
      return word[PKT_W-1 -: 2];
   endfunction

endpackage

// File: rtl/ebm_md_fifo.sv
// Small show-ahead FIFO for scheduler metadata. The head entry is visible on
// rd_data whenever empty is low; a write while full succeeds only if a pop frees a slot.
module ebm_md_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   usedw
);

   localparam int          DEPTH     = 2 ** AW;
   localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   cnt_reg;
   logic          do_wr;
   logic          do_rd;

   assign full  = (cnt_reg == DEPTH_CNT);
   assign empty = (cnt_reg == '0);
   assign usedw = cnt_reg;

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   // Storage is left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

endmodule

// File: rtl/ebm_rd.sv
// Egress buffer manager read side: pops buffer IDs from the scheduler, streams
// the buffer's words to the pktout FIFO and returns the ID to the free pool.
module ebm_rd
   import ebm_rd_pkg::*;
#(
   parameter int         WORD_W       = EBM_WORD_W,
   parameter int         MD_FIFO_AW   = EBM_MD_FIFO_AW,
   parameter logic [7:0] PKTOUT_AFULL = EBM_PKTOUT_AFULL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_ebm_md,
   input  logic                  in_ebm_md_wr,
   output logic                  out_ebm_pkt_valid,
   input  logic                  in_ebm_bandwidth_discard,
   output logic                  out_ebm_buf_rd_en,
   output logic [8+WORD_W-1:0]   out_ebm_buf_rd_addr,
   input  logic [PKT_W-1:0]      in_ebm_buf_rd_data,
   output logic [PKT_W-1:0]      out_ebm_pkt,
   output logic                  out_ebm_pkt_wr,
   input  logic [7:0]            in_ebm_pktout_usedw,
   output logic [7:0]            out_ebm_free_id,
   output logic                  out_ebm_free_id_wr,
   output logic [31:0]           out_ebm_pkt_cnt,
   output logic [31:0]           out_ebm_discard_cnt,
   output logic [31:0]           out_ebm_md_ovf_cnt
);

   localparam logic [WORD_W-1:0] IDX_ZERO = '0;
   localparam logic [WORD_W-1:0] IDX_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};
   localparam logic [WORD_W-1:0] IDX_TWO  = IDX_ONE + IDX_ONE;
   localparam logic [WORD_W-1:0] IDX_MAX  = '1;

   ebm_state_t          state_reg, state_next;
   logic [7:0]          id_reg, id_next;
   logic [PKT_W-1:0]    hold_reg, hold_next;
   logic [WORD_W-1:0]   word_idx_reg, word_idx_next;
   logic [WORD_W-1:0]   ret_idx_reg, ret_idx_next;
   logic                ret_vld_reg, ret_vld_next;
   logic                issue_done_reg, issue_done_next;
   logic [31:0]         pkt_cnt_reg;
   logic [31:0]         discard_cnt_reg;
   logic [31:0]         ovf_cnt_reg;

   logic                fifo_rd;
   logic [7:0]          fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic [MD_FIFO_AW:0] fifo_usedw_unused;

   logic                room;
   logic                pkt_inc;
   logic                disc_inc;
   logic                md_ovf;
   logic [PKT_W-1:0]    ret_word;
   logic                ret_last;

   ebm_md_fifo #(
      .DW (8),
      .AW (MD_FIFO_AW)
   ) u_md_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_ebm_md_wr),
      .wr_data (in_ebm_md),
      .rd_en   (fifo_rd),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .usedw   (fifo_usedw_unused)
   );

   assign room   = (in_ebm_pktout_usedw <= PKTOUT_AFULL);
   assign md_ovf = in_ebm_md_wr && fifo_full && !fifo_rd;

   // The final word slot of a buffer always closes the packet, whatever its header says.
   always_comb begin
      ret_word = in_ebm_buf_rd_data;
      if (ret_idx_reg == IDX_MAX) begin
         ret_word[PKT_W-1 -: 2] = HDR_LAST;
      end
   end

   assign ret_last = (hdr_of(ret_word) == HDR_LAST);

   always_comb begin
      state_next          = state_reg;
      id_next             = id_reg;
      hold_next           = hold_reg;
      word_idx_next       = word_idx_reg;
      ret_idx_next        = ret_idx_reg;
      ret_vld_next        = 1'b0;
      issue_done_next     = issue_done_reg;
      fifo_rd             = 1'b0;
      out_ebm_pkt_valid   = 1'b0;
      out_ebm_buf_rd_en   = 1'b0;
      out_ebm_buf_rd_addr = '0;
      out_ebm_pkt         = '0;
      out_ebm_pkt_wr      = 1'b0;
      out_ebm_free_id     = '0;
      out_ebm_free_id_wr  = 1'b0;
      pkt_inc             = 1'b0;
      disc_inc            = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty && room) begin
               fifo_rd             = 1'b1;
               id_next             = fifo_dout;
               out_ebm_buf_rd_en   = 1'b1;
               out_ebm_buf_rd_addr = {fifo_dout, IDX_ZERO};
               state_next          = ST_FETCH;
            end
         end

         ST_FETCH: begin
            hold_next         = in_ebm_buf_rd_data;
            out_ebm_pkt_valid = 1'b1;
            state_next        = ST_CHK;
         end

         ST_CHK: begin
            if (in_ebm_bandwidth_discard) begin
               out_ebm_free_id_wr = 1'b1;
               out_ebm_free_id    = id_reg;
               disc_inc           = 1'b1;
               state_next         = ST_IDLE;
            end else begin
               out_ebm_pkt    = hold_reg;
               out_ebm_pkt_wr = 1'b1;
               if (hdr_of(hold_reg) == HDR_LAST) begin
                  out_ebm_free_id_wr = 1'b1;
                  out_ebm_free_id    = id_reg;
                  pkt_inc            = 1'b1;
                  state_next         = ST_IDLE;
               end else begin
                  // Word 1 is requested alongside word 0 so the stream stays back-to-back.
                  issue_done_next = 1'b0;
                  state_next      = ST_SEND;
                  if (room) begin
                     out_ebm_buf_rd_en   = 1'b1;
                     out_ebm_buf_rd_addr = {id_reg, IDX_ONE};
                     ret_vld_next        = 1'b1;
                     ret_idx_next        = IDX_ONE;
                     word_idx_next       = IDX_TWO;
                  end else begin
                     word_idx_next = IDX_ONE;
                  end
               end
            end
         end

         ST_SEND: begin
            if (ret_vld_reg) begin
               out_ebm_pkt    = ret_word;
               out_ebm_pkt_wr = 1'b1;
               if (ret_last) begin
                  out_ebm_free_id_wr = 1'b1;
                  out_ebm_free_id    = id_reg;
                  pkt_inc            = 1'b1;
                  state_next         = ST_IDLE;
               end
            end
            if (!(ret_vld_reg && ret_last) && !issue_done_reg && room) begin
               out_ebm_buf_rd_en   = 1'b1;
               out_ebm_buf_rd_addr = {id_reg, word_idx_reg};
               ret_vld_next        = 1'b1;
               ret_idx_next        = word_idx_reg;
               word_idx_next       = word_idx_reg + IDX_ONE;
               if (word_idx_reg == IDX_MAX) begin
                  issue_done_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         id_reg         <= '0;
         hold_reg       <= '0;
         word_idx_reg   <= '0;
         ret_idx_reg    <= '0;
         ret_vld_reg    <= 1'b0;
         issue_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         id_reg         <= id_next;
         hold_reg       <= hold_next;
         word_idx_reg   <= word_idx_next;
         ret_idx_reg    <= ret_idx_next;
         ret_vld_reg    <= ret_vld_next;
         issue_done_reg <= issue_done_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_reg     <= '0;
         discard_cnt_reg <= '0;
         ovf_cnt_reg     <= '0;
      end else begin
         if (pkt_inc) begin
            pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
         end
         if (disc_inc) begin
            discard_cnt_reg <= discard_cnt_reg + 32'd1;
         end
         if (md_ovf) begin
            ovf_cnt_reg <= ovf_cnt_reg + 32'd1;
         end
      end
   end

   assign out_ebm_pkt_cnt     = pkt_cnt_reg;
   assign out_ebm_discard_cnt = discard_cnt_reg;
   assign out_ebm_md_ovf_cnt  = ovf_cnt_reg;

endmodule

// File: tb/tb_ebm_rd.sv
// Directed bench for ebm_rd: models the packet buffer RAM, records every output
// event at the falling edge and checks it against hand-computed expectations.
module tb_ebm_rd;

   typedef logic [133:0] w_t;

   logic         clk;
   logic         rst_n;
   logic [7:0]   in_ebm_md;
   logic         in_ebm_md_wr;
   logic         out_ebm_pkt_valid;
   logic         in_ebm_bandwidth_discard;
   logic         out_ebm_buf_rd_en;
   logic [14:0]  out_ebm_buf_rd_addr;
   w_t           in_ebm_buf_rd_data;
   w_t           out_ebm_pkt;
   logic         out_ebm_pkt_wr;
   logic [7:0]   in_ebm_pktout_usedw;
   logic [7:0]   out_ebm_free_id;
   logic         out_ebm_free_id_wr;
   logic [31:0]  out_ebm_pkt_cnt;
   logic [31:0]  out_ebm_discard_cnt;
   logic [31:0]  out_ebm_md_ovf_cnt;

   w_t           ram [0:32767];
   int           cyc;
   int           tests_run;
   int           tests_failed;
   int           md_cyc;
   int           stall_rd;
   w_t           pkt_q[$];
   int           pkt_cyc_q[$];
   logic [7:0]   free_q[$];
   int           free_cyc_q[$];
   int           pv_cyc_q[$];

   ebm_rd u_dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .in_ebm_md                (in_ebm_md),
      .in_ebm_md_wr             (in_ebm_md_wr),
      .out_ebm_pkt_valid        (out_ebm_pkt_valid),
      .in_ebm_bandwidth_discard (in_ebm_bandwidth_discard),
      .out_ebm_buf_rd_en        (out_ebm_buf_rd_en),
      .out_ebm_buf_rd_addr      (out_ebm_buf_rd_addr),
      .in_ebm_buf_rd_data       (in_ebm_buf_rd_data),
      .out_ebm_pkt              (out_ebm_pkt),
      .out_ebm_pkt_wr           (out_ebm_pkt_wr),
      .in_ebm_pktout_usedw      (in_ebm_pktout_usedw),
      .out_ebm_free_id          (out_ebm_free_id),
      .out_ebm_free_id_wr       (out_ebm_free_id_wr),
      .out_ebm_pkt_cnt          (out_ebm_pkt_cnt),
      .out_ebm_discard_cnt      (out_ebm_discard_cnt),
      .out_ebm_md_ovf_cnt       (out_ebm_md_ovf_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer RAM: registered read, data one cycle after rd_en.
   always @(posedge clk) begin
      if (out_ebm_buf_rd_en) begin
         in_ebm_buf_rd_data <= ram[out_ebm_buf_rd_addr];
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_ebm_pkt_wr) begin
            pkt_q.push_back(out_ebm_pkt);
            pkt_cyc_q.push_back(cyc);
         end
         if (out_ebm_free_id_wr) begin
            free_q.push_back(out_ebm_free_id);
            free_cyc_q.push_back(cyc);
         end
         if (out_ebm_pkt_valid) begin
            pv_cyc_q.push_back(cyc);
         end
         if (out_ebm_buf_rd_en && in_ebm_pktout_usedw > 8'd240) begin
            stall_rd++;
         end
      end
   end

   task automatic check_eq(input string tag, input w_t got, input w_t exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic w_t mk(input logic [1:0] hdr, input logic [7:0] id, input int idx);
      return {hdr, 108'hC0FFEE, id, 16'(idx)};
   endfunction

   task automatic load(input logic [7:0] id, input int idx, input logic [1:0] hdr);
      ram[{id, 7'(idx)}] = mk(hdr, id, idx);
   endtask

   task automatic clear_q();
      pkt_q.delete();
      pkt_cyc_q.delete();
      free_q.delete();
      free_cyc_q.delete();
      pv_cyc_q.delete();
      stall_rd = 0;
   endtask

   task automatic send_md(input logic [7:0] id);
      @(posedge clk);
      #1;
      in_ebm_md    = id;
      in_ebm_md_wr = 1'b1;
      md_cyc       = cyc;
      @(posedge clk);
      #1;
      in_ebm_md_wr = 1'b0;
   endtask

   task automatic wait_free(input int n, input int budget);
      int k;
      k = 0;
      while (free_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check_eq("free_count", w_t'(free_q.size()), w_t'(n));
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_ctl"}, w_t'({out_ebm_pkt_valid, out_ebm_buf_rd_en, out_ebm_pkt_wr, out_ebm_free_id_wr}), w_t'(0));
      check_eq({tag, "_addr"}, w_t'(out_ebm_buf_rd_addr), w_t'(0));
      check_eq({tag, "_pkt"}, out_ebm_pkt, w_t'(0));
      check_eq({tag, "_free_id"}, w_t'(out_ebm_free_id), w_t'(0));
      check_eq({tag, "_cnts"}, w_t'({out_ebm_pkt_cnt, out_ebm_discard_cnt, out_ebm_md_ovf_cnt}), w_t'(0));
   endtask

   initial begin
      int k;
      cyc                      = 0;
      tests_run                = 0;
      tests_failed             = 0;
      stall_rd                 = 0;
      md_cyc                   = 0;
      rst_n                    = 1'b0;
      in_ebm_md                = '0;
      in_ebm_md_wr             = 1'b0;
      in_ebm_bandwidth_discard = 1'b0;
      in_ebm_pktout_usedw      = '0;
      in_ebm_buf_rd_data       = '0;

      load(8'h05, 0, 2'b01); load(8'h05, 1, 2'b11); load(8'h05, 2, 2'b10);
      load(8'h07, 0, 2'b01); load(8'h07, 1, 2'b10);
      load(8'h09, 0, 2'b10);
      for (int i = 0; i < 10; i++) load(8'h0A, i, (i == 0) ? 2'b01 : (i == 9) ? 2'b10 : 2'b11);
      for (int i = 0; i < 18; i++) load(8'(32'h20 + i), 0, 2'b10);
      for (int i = 0; i < 128; i++) load(8'h40, i, (i == 0) ? 2'b01 : 2'b11);

      #2;
      check_outputs_zero("rst_held");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("rst_rel");

      // Three-word packet
      clear_q();
      send_md(8'h05);
      wait_free(1, 40);
      check_eq("t1_pv_lat", w_t'(pv_cyc_q[0] - md_cyc), w_t'(2));
      check_eq("t1_nwords", w_t'(pkt_q.size()), w_t'(3));
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("t1_word%0d", i), pkt_q[i], mk((i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'b10, 8'h05, i));
      end
      check_eq("t1_first_wr_lat", w_t'(pkt_cyc_q[0] - pv_cyc_q[0]), w_t'(1));
      check_eq("t1_back_to_back", w_t'(pkt_cyc_q[2] - pkt_cyc_q[0]), w_t'(2));
      check_eq("t1_free_id", w_t'(free_q[0]), w_t'(8'h05));
      check_eq("t1_free_with_last", w_t'(free_cyc_q[0]), w_t'(pkt_cyc_q[2]));
      check_eq("t1_pkt_cnt", w_t'(out_ebm_pkt_cnt), w_t'(1));

      // Discarded packet
      clear_q();
      in_ebm_bandwidth_discard = 1'b1;
      send_md(8'h07);
      wait_free(1, 40);
      in_ebm_bandwidth_discard = 1'b0;
      check_eq("t2_nwords", w_t'(pkt_q.size()), w_t'(0));
      check_eq("t2_free_id", w_t'(free_q[0]), w_t'(8'h07));
      check_eq("t2_free_in_chk", w_t'(free_cyc_q[0] - pv_cyc_q[0]), w_t'(1));
      check_eq("t2_discard_cnt", w_t'(out_ebm_discard_cnt), w_t'(1));
      check_eq("t2_pkt_cnt", w_t'(out_ebm_pkt_cnt), w_t'(1));

      // Single-word packet
      clear_q();
      send_md(8'h09);
      wait_free(1, 40);
      repeat (4) @(negedge clk);
      check_eq("t3_nwords", w_t'(pkt_q.size()), w_t'(1));
      check_eq("t3_word", pkt_q[0], mk(2'b10, 8'h09, 0));
      check_eq("t3_free_id", w_t'(free_q[0]), w_t'(8'h09));
      check_eq("t3_free_same_cyc", w_t'(free_cyc_q[0]), w_t'(pkt_cyc_q[0]));
      check_eq("t3_pkt_cnt", w_t'(out_ebm_pkt_cnt), w_t'(2));

      // Four-cycle stall mid-packet
      clear_q();
      send_md(8'h0A);
      k = 0;
      while (pkt_q.size() < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      in_ebm_pktout_usedw = 8'd241;
      repeat (4) @(posedge clk);
      #1;
      in_ebm_pktout_usedw = 8'd0;
      wait_free(1, 100);
      check_eq("t4_rd_in_stall", w_t'(stall_rd), w_t'(0));
      check_eq("t4_nwords", w_t'(pkt_q.size()), w_t'(10));
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("t4_word%0d", i), pkt_q[i], mk((i == 0) ? 2'b01 : (i == 9) ? 2'b10 : 2'b11, 8'h0A, i));
      end
      check_eq("t4_span", w_t'(pkt_cyc_q[9] - pkt_cyc_q[0]), w_t'(13));
      check_eq("t4_free_id", w_t'(free_q[0]), w_t'(8'h0A));

      // md FIFO overflow and in-order drain
      clear_q();
      @(posedge clk);
      #1;
      in_ebm_pktout_usedw = 8'd255;
      for (int i = 0; i < 18; i++) begin
         in_ebm_md    = 8'(32'h20 + i);
         in_ebm_md_wr = 1'b1;
         @(posedge clk);
         #1;
      end
      in_ebm_md_wr = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t5_ovf_cnt", w_t'(out_ebm_md_ovf_cnt), w_t'(2));
      check_eq("t5_no_tx_full", w_t'(pkt_q.size()), w_t'(0));
      @(posedge clk);
      #1;
      in_ebm_pktout_usedw = 8'd0;
      wait_free(16, 200);
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("t5_free%0d", i), w_t'(free_q[i]), w_t'(8'(32'h20 + i)));
         check_eq($sformatf("t5_word%0d", i), pkt_q[i], mk(2'b10, 8'(32'h20 + i), 0));
      end
      check_eq("t5_pkt_gap", w_t'(free_cyc_q[1] - free_cyc_q[0]), w_t'(3));
      check_eq("t5_pkt_cnt", w_t'(out_ebm_pkt_cnt), w_t'(19));
      check_eq("t5_ovf_hold", w_t'(out_ebm_md_ovf_cnt), w_t'(2));

      // Full 128-word buffer with no terminating header
      clear_q();
      send_md(8'h40);
      wait_free(1, 400);
      check_eq("t6_nwords", w_t'(pkt_q.size()), w_t'(128));
      check_eq("t6_first", pkt_q[0], mk(2'b01, 8'h40, 0));
      check_eq("t6_mid", pkt_q[64], mk(2'b11, 8'h40, 64));
      check_eq("t6_forced_last", pkt_q[127], mk(2'b10, 8'h40, 127));
      check_eq("t6_span", w_t'(pkt_cyc_q[127] - pkt_cyc_q[0]), w_t'(127));
      check_eq("t6_free_id", w_t'(free_q[0]), w_t'(8'h40));
      check_eq("t6_free_with_last", w_t'(free_cyc_q[0]), w_t'(pkt_cyc_q[127]));
      check_eq("t6_pkt_cnt", w_t'(out_ebm_pkt_cnt), w_t'(20));

      // Asynchronous reset in the middle of a packet
      clear_q();
      send_md(8'h40);
      k = 0;
      while (pkt_q.size() < 10 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("t7_started", w_t'(pkt_q.size() >= 10), w_t'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t7_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      repeat (10) @(negedge clk);
      check_eq("t7_no_free", w_t'(free_q.size()), w_t'(0));
      check_eq("t7_no_words", w_t'(pkt_q.size()), w_t'(0));
      check_outputs_zero("t7_after");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
